dadda_mult_pipe: RTL
====================

// Module: dadda_mult_pipe
// PURPOSE
//  Parametrised, pipelined Dadda-tree multiplier with a valid/ready stream interface.
//  Accepts one WIDTH x WIDTH operand pair per cycle. Returns the 2*WIDTH-bit product
//  STAGES cycles later, with a sideband tag carried alongside each product.
//  Successor to the combinational 8x8 Dadda multiplier: same tree, generalised in width,
//  registered between reduction levels, and able to stall under backpressure.
// PARAMETERS
//  WIDTH   8  operand width; legal 4..32. Product width is 2*WIDTH.
//  STAGES  2  pipeline depth = latency in cycles; legal 1..4.
//             Register cuts are placed after every ceil(L/STAGES) Dadda levels;
//             the final CPA always sits in the last stage.
//  TAG_W   4  width of the sideband tag carried with each operand pair.
// PORTS
//  clk        in   1         clock; all state changes on the rising edge
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   1         a/b/in_tag (and tc) are valid
//  in_ready   out  1         block accepts the pair this cycle
//  a          in   WIDTH     multiplicand
//  b          in   WIDTH     multiplier
//  in_tag     in   TAG_W     sideband, returned unchanged with the product
//  tc         in   1         two's-complement mode; present only with DADDA_SIGNED_EN
//  out_valid  out  1         p/out_tag are valid
//  out_ready  in   1         downstream accepts the product this cycle
//  p          out  2*WIDTH   product
//  out_tag    out  TAG_W     tag of the returned product
//  inflight   out  3         number of valid pairs in the pipe (0..STAGES)
// BEHAVIOUR
//  - Reset (async assert, sync deassert on clk): all stage valid bits, out_valid, p,
//    out_tag and inflight go to 0; in_ready = 1 in the first cycle after release.
//  - Handshakes: accept when in_valid & in_ready; retire when out_valid & out_ready.
//  - Stall rule: advance = ~out_valid | out_ready. When advance = 0, every stage holds
//    its data and valid; in_ready = advance (combinational from out_ready and out_valid).
//  - Occupancy: each stage has a valid bit; bubbles move forward on advance.
//    Throughput is one product per cycle when out_ready is held at 1.
//  - Latency: a pair accepted at edge N appears on p at edge N+STAGES if no stall
//    occurs. Products exit in acceptance order; out_tag follows its own pair.
//  - inflight: incremented on accept, decremented on retire; unchanged when both occur
//    in the same cycle. It never exceeds STAGES.
//  - Arithmetic: p = a*b exactly, modulo 2^(2*WIDTH); there is no overflow.
//    The tree is built with HA/CSA cells, using the Dadda height sequence
//    2,3,4,6,9,13,19,28 down to 2 rows, followed by a ripple CPA.
//  - Holding stages keep their last data, but only valid-qualified outputs are
//    meaningful. p holds its value while out_valid = 0.
//  - If rst_n is asserted mid-operation, all in-flight pairs are discarded and no
//    partial product is emitted afterwards.
//  - If in_valid = 0 while advance = 1, a bubble enters stage 1.
// CONFIGURATION
//  DADDA_SIGNED_EN defined:
//   - port tc is present and is captured per pair.
//   - tc = 1: operands are treated as two's complement (Baugh-Wooley: inverted MSB
//     partial products plus constant-1 correction bits at columns WIDTH and 2*WIDTH-1).
//   - tc = 0: unsigned.
//  DADDA_SIGNED_EN undefined:
//   - no tc port; unsigned only; no correction bits in the tree.
// TESTING
//  T1 WIDTH=8, STAGES=2, out_ready=1: a=255, b=255, tag=3 at cycle 0
//     -> p=16'hFE01, out_tag=3, out_valid=1 after exactly 2 edges.
//  T2 Back-to-back: pairs (3,5),(0,200),(17,15) on consecutive cycles
//     -> p = 15, 0, 255 on consecutive cycles; inflight peaks at 2.
//  T3 Backpressure: out_ready=0 for 5 cycles with 2 pairs inside
//     -> in_ready=0, p and out_tag stable, inflight=2; after release both exit in order.
//  T4 DADDA_SIGNED_EN, tc=1: a=8'h80, b=8'h80 -> p=16'h4000; a=8'hFF, b=8'h01 -> p=16'hFFFF.
//     Same operands with tc=0 -> p=16'h4000 and 16'h00FF.
//  T5 rst_n pulsed low with 2 pairs in flight -> out_valid=0 and inflight=0 immediately;
//     no product emitted afterwards.
//  T6 Random sweep, WIDTH=16, STAGES=3, random in_valid/out_ready
//     -> every product matches the a*b model in order; tags are preserved.

Source files
------------

// File: rtl/dadda_mult_pipe_if.sv
// Stream interface for dadda_mult_pipe: operand/tag input channel and product/tag output channel.
// With DADDA_SIGNED_EN defined, the input channel also carries the per-pair tc mode bit.
interface dadda_mult_pipe_if #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [TAG_W-1:0]     in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   p;
   logic [TAG_W-1:0]     out_tag;
`ifdef DADDA_SIGNED_EN
   logic                 tc;

   modport master (output in_valid, a, b, in_tag, tc, out_ready,
                   input  in_ready, out_valid, p, out_tag);
   modport slave  (input  in_valid, a, b, in_tag, tc, out_ready,
                   output in_ready, out_valid, p, out_tag);
`else
   modport master (output in_valid, a, b, in_tag, out_ready,
                   input  in_ready, out_valid, p, out_tag);
   modport slave  (input  in_valid, a, b, in_tag, out_ready,
                   output in_ready, out_valid, p, out_tag);
`endif
endinterface

// File: rtl/dadda_mult_pipe.sv
// Pipelined WIDTH x WIDTH Dadda-tree multiplier with valid/ready stall, tag sideband and occupancy count.
// Define DADDA_SIGNED_EN to add the per-pair tc input (Baugh-Wooley two's-complement mode).
module dadda_mult_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int TAG_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   dadda_mult_pipe_if.slave  bus,
   output logic [2:0]        inflight
);
   localparam int PW   = 2 * WIDTH;
   localparam int MAXH = WIDTH;

   typedef logic [MAXH-1:0] col_t;
   typedef col_t [PW-1:0]   mat_t;

   function automatic int init_height(input int c);
      int h = 0;
      for (int i = 0; i < WIDTH; i++)
         if (c - i >= 0 && c - i < WIDTH) h++;
`ifdef DADDA_SIGNED_EN
      if (c == WIDTH || c == PW - 1) h++;
`endif
      return h;
   endfunction

   function automatic int num_levels();
      int n = 0;
      for (int d = 2; d < WIDTH; d = d * 3 / 2) n++;
      return n;
   endfunction

   localparam int LEVELS = num_levels();
   localparam int LPS    = (LEVELS + STAGES - 1) / STAGES;

   // Level 0 uses the largest Dadda height below the tallest column; the last level targets 2.
   function automatic int level_target(input int lvl);
      int d = 2;
      for (int i = 0; i < LEVELS - 1 - lvl; i++) d = d * 3 / 2;
      return d;
   endfunction

   function automatic mat_t build_pp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic tc);
      mat_t m;
      int   h [PW];
      logic bit_v;
      m = '0;
      for (int c = 0; c < PW; c++) h[c] = 0;
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            bit_v = x[i] & y[j];
            if (tc && ((i == WIDTH - 1) != (j == WIDTH - 1))) bit_v = ~bit_v;
            m[i+j][h[i+j]] = bit_v;
            h[i+j]++;
         end
      end
`ifdef DADDA_SIGNED_EN
      m[WIDTH][h[WIDTH]] = tc;
      m[PW-1][0]         = tc;
`endif
      return m;
   endfunction

   // Column heights are data independent, so levels below lo are replayed for bookkeeping only.
   function automatic mat_t reduce_levels(input mat_t m, input int lo, input int hi);
      mat_t cur, nxt;
      int   h [PW];
      int   hn [PW];
      int   d, cnt, rp, wp;
      logic s, cy;
      cur = m;
      for (int c = 0; c < PW; c++) h[c] = init_height(c);
      for (int lvl = 0; lvl < hi; lvl++) begin
         d   = level_target(lvl);
         nxt = '0;
         for (int c = 0; c < PW; c++) hn[c] = 0;
         for (int c = 0; c < PW; c++) begin
            cnt = h[c] + hn[c];
            rp  = 0;
            wp  = hn[c];
            for (int k = 0; k < MAXH; k++) begin
               if (cnt > d) begin
                  if (cnt == d + 1) begin
                     s   = cur[c][rp] ^ cur[c][rp+1];
                     cy  = cur[c][rp] & cur[c][rp+1];
                     rp  = rp + 2;
                     cnt = cnt - 1;
                  end else begin
                     s   = cur[c][rp] ^ cur[c][rp+1] ^ cur[c][rp+2];
                     cy  = (cur[c][rp] & cur[c][rp+1]) |
                           (cur[c][rp+2] & (cur[c][rp] ^ cur[c][rp+1]));
                     rp  = rp + 3;
                     cnt = cnt - 2;
                  end
                  nxt[c][wp] = s;
                  wp = wp + 1;
                  if (c + 1 < PW) begin
                     nxt[c+1][hn[c+1]] = cy;
                     hn[c+1] = hn[c+1] + 1;
                  end
               end
            end
            for (int k = 0; k < MAXH; k++) begin
               if (k >= rp && k < h[c]) begin
                  nxt[c][wp] = cur[c][k];
                  wp = wp + 1;
               end
            end
            hn[c] = wp;
         end
         if (lvl >= lo) cur = nxt;
         for (int c = 0; c < PW; c++) h[c] = hn[c];
      end
      return cur;
   endfunction

   function automatic logic [PW-1:0] final_add(input mat_t m);
      logic [PW-1:0] sum;
      logic          carry;
      carry = 1'b0;
      for (int c = 0; c < PW; c++) begin
         sum[c] = m[c][0] ^ m[c][1] ^ carry;
         carry  = (m[c][0] & m[c][1]) | (carry & (m[c][0] ^ m[c][1]));
      end
      return sum;
   endfunction

   logic             vld_reg [STAGES];
   logic [TAG_W-1:0] tag_reg [STAGES];
   mat_t             mat_in  [STAGES];
   logic [PW-1:0]    p_reg;
   logic [2:0]       inflight_reg;
   logic             advance, accept, retire, tc_in;

`ifdef DADDA_SIGNED_EN
   assign tc_in = bus.tc;
`else
   assign tc_in = 1'b0;
`endif

   assign advance      = ~vld_reg[STAGES-1] | bus.out_ready;
   assign accept       = bus.in_valid & advance;
   assign retire       = vld_reg[STAGES-1] & bus.out_ready;
   assign bus.in_ready = advance;
   assign mat_in[0]    = build_pp(bus.a, bus.b, tc_in);

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = (gi * LPS < LEVELS) ? gi * LPS : LEVELS;
      localparam int HI = (gi < STAGES - 1 && (gi + 1) * LPS < LEVELS) ? (gi + 1) * LPS : LEVELS;
      logic             vld_d;
      logic [TAG_W-1:0] tag_d;

      if (gi == 0) begin : g_head
         assign vld_d = bus.in_valid;
         assign tag_d = bus.in_tag;
      end else begin : g_body
         assign vld_d = vld_reg[gi-1];
         assign tag_d = tag_reg[gi-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_reg[gi] <= 1'b0;
            tag_reg[gi] <= '0;
         end else if (advance) begin
            vld_reg[gi] <= vld_d;
            if (vld_d) tag_reg[gi] <= tag_d;
         end
      end

      if (gi < STAGES - 1) begin : g_cut
         mat_t mat_reg;
         always_ff @(posedge clk) begin
            if (advance && vld_d) mat_reg <= reduce_levels(mat_in[gi], LO, HI);
         end
         assign mat_in[gi+1] = mat_reg;
      end else begin : g_cpa
         // The output register only loads real pairs, so p holds through bubbles.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               p_reg <= '0;
            else if (advance && vld_d)
               p_reg <= final_add(reduce_levels(mat_in[gi], LO, HI));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_reg <= 3'd0;
      end else begin
         case ({accept, retire})
            2'b10:   inflight_reg <= inflight_reg + 3'd1;
            2'b01:   inflight_reg <= inflight_reg - 3'd1;
            default: inflight_reg <= inflight_reg;
         endcase
      end
   end

   assign bus.out_valid = vld_reg[STAGES-1];
   assign bus.p         = p_reg;
   assign bus.out_tag   = tag_reg[STAGES-1];
   assign inflight      = inflight_reg;
endmodule
